sub64_iter: RTL

- Multi-cycle 64-bit two's-complement subtractor: computes valOut = val1 - val2, plus borrow/overflow/zero/negative flags.
- Processes SLICE_W bits per clock, least-significant slice first, as val1 + ~val2 + 1 with a registered carry between slices.
- Uses valid/ready handshakes on input and output.
- Sits in the ALU datapath next to the combinational adder and serves compare/branch and SUBS-style operations where latency is acceptable.

---
 rtl/sub64_iter_if.sv | 25 ++
 rtl/sub64_iter.sv | 103 ++++++++++
 2 files changed

// File: rtl/sub64_iter_if.sv
// Operand and result channel of the iterative 64-bit subtractor.
// master drives operands and result acceptance; slave is the subtractor.
interface sub64_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] val1;
    logic [63:0] val2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valOut;
    logic        borrow;
    logic        overflow;
    logic        zero;
    logic        negative;

    modport master (
        output in_valid, val1, val2, out_ready,
        input  in_ready, out_valid, valOut, borrow, overflow, zero, negative
    );

    modport slave (
        input  in_valid, val1, val2, out_ready,
        output in_ready, out_valid, valOut, borrow, overflow, zero, negative
    );
endinterface

// File: rtl/sub64_iter.sv
// Multi-cycle 64-bit subtractor: val1 + ~val2 + 1, SLICE_W bits per clock, LSB slice first.
// Result and flags are registered on DONE entry and held until the next DONE entry.
module sub64_iter #(
    parameter int SLICE_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    sub64_iter_if.slave  bus
);
    localparam int NSLICE = 64 / SLICE_W;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [63:0]         a, b, res;
    logic                carry;
    logic [KW-1:0]       k;
    logic                in_ready_r, out_valid_r;
    logic [63:0]         val_out_r;
    logic                borrow_r, overflow_r, zero_r, negative_r;

    logic [5:0]          base;
    logic [SLICE_W-1:0]  a_s, b_s;
    logic [SLICE_W:0]    sum;
    logic [63:0]         res_nxt;
    logic                last;

    always_comb begin
        base    = 6'(int'(k) * SLICE_W);
        a_s     = a[base +: SLICE_W];
        b_s     = b[base +: SLICE_W];
        sum     = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE_W{1'b0}}, carry};
        // res_nxt includes the slice being computed so the final edge sees the full result
        res_nxt = res;
        res_nxt[base +: SLICE_W] = sum[SLICE_W-1:0];
        last    = (k == KW'(NSLICE - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            res         <= '0;
            carry       <= 1'b0;
            k           <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            val_out_r   <= '0;
            borrow_r    <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a          <= bus.val1;
                        b          <= bus.val2;
                        res        <= '0;
                        carry      <= 1'b1;
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_nxt;
                    carry <= sum[SLICE_W];
                    if (last) begin
                        k           <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        val_out_r   <= res_nxt;
                        borrow_r    <= ~sum[SLICE_W];
                        overflow_r  <= (a[63] != b[63]) && (res_nxt[63] != a[63]);
                        zero_r      <= (res_nxt == '0);
                        negative_r  <= res_nxt[63];
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.valOut    = val_out_r;
    assign bus.borrow    = borrow_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
    assign bus.negative  = negative_r;
endmodule
